// File: rtl/calendar_ctrl.sv
// Day/month/year sequencer that advances on the midnight tick and accepts validated date loads over a req/ack handshake.
// It also time-multiplexes day, month and year onto one registered display bus.
module calendar_ctrl #(
  parameter int YEAR_W   = 7,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              day_tick,
  input  logic              set_req,
  input  logic [4:0]        set_day,
  input  logic [3:0]        set_month,
  input  logic [YEAR_W-1:0] set_year,
  output logic              set_ack,
  output logic              set_err,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic              month_wrap,
  output logic [1:0]        field_sel,
  output logic [YEAR_W-1:0] databus
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, ACK, WAIT_REL} state_t;

  state_t            state, state_nxt;
  logic              pend;
  logic              err_q;
  logic [4:0]        h_day;
  logic [3:0]        h_month;
  logic [YEAR_W-1:0] h_year;
  logic [SCAN_W-1:0] scan_cnt;
  logic              roll;
  logic              valid;

  // Every year 00..99 divisible by four is a leap year in the 2000-2099 window.
  function automatic logic [4:0] dim(input logic [3:0] m, input logic [YEAR_W-1:0] y);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  assign roll  = (state == IDLE) && (day_tick || pend);
  assign valid = (h_month >= 4'd1) && (h_month <= 4'd12) &&
                 (h_year <= YEAR_W'(99)) &&
                 (h_day >= 5'd1) && (h_day <= dim(h_month, h_year));

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // A roll takes priority in IDLE; the held request is picked up the cycle after.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (!roll && set_req) state_nxt = CHECK;
      CHECK:    state_nxt = ACK;
      ACK:      state_nxt = WAIT_REL;
      WAIT_REL: if (!set_req) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    set_ack = (state == ACK);
    set_err = (state == ACK) && err_q;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      day        <= 5'd1;
      month      <= 4'd1;
      year       <= '0;
      month_wrap <= 1'b0;
      pend       <= 1'b0;
      err_q      <= 1'b0;
      h_day      <= '0;
      h_month    <= '0;
      h_year     <= '0;
    end else begin
      month_wrap <= 1'b0;
      if (roll) begin
        pend <= 1'b0;
        if (day < dim(month, year)) begin
          day <= day + 5'd1;
        end else begin
          day <= 5'd1;
          if (month < 4'd12) begin
            month <= month + 4'd1;
          end else begin
            month      <= 4'd1;
            month_wrap <= 1'b1;
            year       <= (year == YEAR_W'(99)) ? '0 : year + YEAR_W'(1);
          end
        end
      end else begin
        if (day_tick && state != IDLE) pend <= 1'b1;
        if (state == IDLE && set_req) begin
          h_day   <= set_day;
          h_month <= set_month;
          h_year  <= set_year;
        end
      end
      if (state == CHECK) begin
        err_q <= !valid;
        if (valid) begin
          day   <= h_day;
          month <= h_month;
          year  <= h_year;
        end
      end
    end
  end

  // databus follows field_sel by one cycle because both are registered.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      scan_cnt  <= '0;
      field_sel <= 2'd0;
      databus   <= '0;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt  <= '0;
        field_sel <= (field_sel == 2'd2) ? 2'd0 : field_sel + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      case (field_sel)
        2'd0:    databus <= YEAR_W'(day);
        2'd1:    databus <= YEAR_W'(month);
        default: databus <= year;
      endcase
    end
  end

endmodule

// File: tb/tb_calendar_ctrl.sv
// Directed bench for calendar_ctrl covering the scan sequence, roll-over, leap years and the load handshake.
module tb_calendar_ctrl;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       day_tick;
  logic       set_req;
  logic [4:0] set_day;
  logic [3:0] set_month;
  logic [6:0] set_year;
  logic       set_ack;
  logic       set_err;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic       month_wrap;
  logic [1:0] field_sel;
  logic [6:0] databus;

  int n_cmp = 0;
  int n_bad = 0;

  calendar_ctrl #(.YEAR_W(7), .SCAN_DIV(4)) dut (
    .clk(clk), .clear_n(clear_n), .day_tick(day_tick), .set_req(set_req),
    .set_day(set_day), .set_month(set_month), .set_year(set_year),
    .set_ack(set_ack), .set_err(set_err), .day(day), .month(month), .year(year),
    .month_wrap(month_wrap), .field_sel(field_sel), .databus(databus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_date(input int d, input int m, input int y);
    chk("day", day, d);
    chk("month", month, m);
    chk("year", year, y);
  endtask

  // Full handshake: expects ack two cycles after request, then releases.
  task automatic do_set(input int d, input int m, input int y, input int exp_err);
    int n;
    set_day   = 5'(d);
    set_month = 4'(m);
    set_year  = 7'(y);
    set_req   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!set_ack && n < 8);
    chk("set_lat", n, 2);
    chk("set_err", set_err, exp_err);
    set_req = 1'b0;
    @(negedge clk);
    chk("ack_pulse", set_ack, 0);
    @(negedge clk);
  endtask

  task automatic tick();
    day_tick = 1'b1;
    @(negedge clk);
    day_tick = 1'b0;
  endtask

  initial begin
    int n;
    clear_n   = 1'b0;
    day_tick  = 1'b0;
    set_req   = 1'b0;
    set_day   = '0;
    set_month = '0;
    set_year  = '0;
    repeat (2) @(negedge clk);

    // T1: reset values and scan sequence
    chk_date(1, 1, 0);
    chk("rst_ack", set_ack, 0);
    chk("rst_err", set_err, 0);
    chk("rst_wrap", month_wrap, 0);
    chk("rst_fsel", field_sel, 0);
    chk("rst_bus", databus, 0);
    clear_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("scan_fsel", field_sel, (k / 4) % 3);
      chk("scan_bus", databus, (((k - 1) / 4) % 3 == 2) ? 0 : 1);
    end
    chk_date(1, 1, 0);

    // T2: year wrap
    do_set(31, 12, 99, 0);
    chk_date(31, 12, 99);
    tick();
    chk_date(1, 1, 0);
    chk("wrap_hi", month_wrap, 1);
    @(negedge clk);
    chk("wrap_lo", month_wrap, 0);

    // T3: February lengths
    do_set(28, 2, 23, 0);
    tick();
    chk_date(1, 3, 23);
    chk("nowrap", month_wrap, 0);
    do_set(28, 2, 24, 0);
    tick();
    chk_date(29, 2, 24);
    tick();
    chk_date(1, 3, 24);
    do_set(28, 2, 0, 0);
    tick();
    chk_date(29, 2, 0);

    // T4: rejected loads leave the date alone
    do_set(31, 4, 10, 1);
    chk_date(29, 2, 0);
    do_set(0, 5, 10, 1);
    do_set(15, 13, 10, 1);
    do_set(1, 1, 100, 1);
    do_set(29, 2, 23, 1);
    chk_date(29, 2, 0);

    // T5: tick and request together; roll first, load after
    do_set(30, 6, 5, 0);
    set_day = 5'd10; set_month = 4'd10; set_year = 7'd10;
    set_req = 1'b1;
    day_tick = 1'b1;
    @(negedge clk);
    day_tick = 1'b0;
    chk_date(1, 7, 5);
    n = 1;
    while (!set_ack && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("t5_lat", n, 3);
    chk("t5_err", set_err, 0);
    chk_date(10, 10, 10);
    set_req = 1'b0;
    repeat (2) @(negedge clk);

    // T6: tick while waiting for release is deferred to IDLE
    set_day = 5'd30; set_month = 4'd9; set_year = 7'd7;
    set_req = 1'b1;
    repeat (3) @(negedge clk);
    day_tick = 1'b1;
    @(negedge clk);
    day_tick = 1'b0;
    set_req  = 1'b0;
    chk_date(30, 9, 7);
    @(negedge clk);
    chk_date(30, 9, 7);
    @(negedge clk);
    chk_date(1, 10, 7);

    // Reset during CHECK aborts the request
    set_day = 5'd5; set_month = 4'd5; set_year = 7'd5;
    set_req = 1'b1;
    @(negedge clk);
    clear_n = 1'b0;
    #1;
    chk_date(1, 1, 0);
    chk("abort_ack", set_ack, 0);
    set_req = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (set_ack) n++;
    end
    chk("abort_noack", n, 0);
    chk_date(1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
